stage_if: RTL and testbench

Instruction-fetch stage that drives the IF/ID pipeline register feeding the decode stage's instr and pc_id inputs.
- Owns the program counter and talks to a synchronous instruction memory (1-cycle read latency).
- Accepts a taken-jump redirect from the execute stage and a hazard stall.
- Detects a HALT opcode and freezes fetch.

---
 rtl/stage_if_pkg.sv | 24 ++
 rtl/if_pc_reg.sv | 45 ++++
 rtl/stage_if.sv | 89 ++++++++
 tb/tb_stage_if.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared pipeline constants and fetch-stage encodings
package stage_if_pkg;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
  localparam logic [5:0]  HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_JUMP = 2'd2
  } pc_sel_e;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter and issued-address register with next-PC select
module if_pc_reg
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = stage_if_pkg::RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  pc_sel_e     pc_sel,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] req_pc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;

  // A redirect leaves req_pc alone: the FILL edge that follows reloads it.
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (pc_sel)
      PC_INC: begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
      end
      PC_JUMP: pc_d = align_word(jump_target);
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0000_0000;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign pc     = pc_q;
  assign req_pc = req_pc_q;

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction fetch stage driving the IF/ID register
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = stage_if_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD    = stage_if_pkg::NOP_WORD,
  parameter logic [5:0]  HALT_OPCODE = stage_if_pkg::HALT_OPCODE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc_id,
  output logic        halted
);

  if_state_e   state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  pc_sel_e     pc_sel;
  logic [31:0] pc;
  logic [31:0] req_pc;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock       (clock),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .jump_target (jump_target),
    .pc          (pc),
    .req_pc      (req_pc)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    pc_sel  = PC_HOLD;
    if (jump_taken) begin
      pc_sel  = PC_JUMP;
      instr_d = NOP_WORD;
      pc_id_d = 32'h0000_0000;
      state_d = ST_FILL;
    end else if (state_q == ST_HALTED) begin
      instr_d = NOP_WORD;
      pc_id_d = 32'h0000_0000;
    end else if (!stall) begin
      pc_sel = PC_INC;
      if (state_q == ST_RUN) begin
        instr_d = imem_data;
        pc_id_d = req_pc + 32'd4;
        // The HALT word itself still reaches decode before fetch freezes.
        if (imem_data[31:26] == HALT_OPCODE) begin
          state_d = ST_HALTED;
        end
      end else begin
        instr_d = NOP_WORD;
        pc_id_d = 32'h0000_0000;
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FILL;
      instr_q <= NOP_WORD;
      pc_id_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
    end
  end

  // A redirect must fetch even when a stall or HALTED would otherwise gate memory.
  assign imem_en   = jump_taken | (!stall && (state_q != ST_HALTED));
  assign imem_addr = pc;
  assign instr     = instr_q;
  assign pc_id     = pc_id_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - scoreboard bench for stage_if against a fetch-stream model
module tb_stage_if;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instr;
  logic [31:0] pc_id;
  logic        halted;

  stage_if dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_data   (imem_data),
    .instr       (instr),
    .pc_id       (pc_id),
    .halted      (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit halt_mode = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_mode && a == 32'h8) return 32'hFC00_0000;
    return 32'h1000_0000 | a;
  endfunction

  always @(posedge clock) begin
    if (imem_en) imem_data <= mem_word(imem_addr);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_id;
    logic [31:0] addr;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  // Model: an address stream with at most one word in flight, plus a halted flag.
  logic [31:0] m_next;
  logic [31:0] m_inflight[$];
  logic        m_halted;
  logic [31:0] m_instr;
  logic [31:0] m_pc_id;

  task automatic model_edge(input logic r, input logic s, input logic j, input logic [31:0] t);
    logic [31:0] a;
    logic [31:0] w;
    if (r) begin
      m_next = 32'h0; m_inflight.delete(); m_halted = 1'b0;
      m_instr = 32'h0; m_pc_id = 32'h0;
    end else if (j) begin
      m_next = t & 32'hFFFF_FFFC; m_inflight.delete(); m_halted = 1'b0;
      m_instr = 32'h0; m_pc_id = 32'h0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_pc_id = 32'h0;
    end else if (!s) begin
      if (m_inflight.size() > 0) begin
        a = m_inflight.pop_front();
        w = mem_word(a);
        m_instr = w;
        m_pc_id = a + 32'd4;
        if (w[31:26] == 6'h3F) m_halted = 1'b1;
      end else begin
        m_instr = 32'h0; m_pc_id = 32'h0;
      end
      m_inflight.push_back(m_next);
      m_next = m_next + 32'd4;
    end
    sb.push_back('{instr: m_instr, pc_id: m_pc_id, addr: m_next, halted: m_halted});
  endtask

  task automatic step(input logic r, input logic s, input logic j, input logic [31:0] t);
    @(negedge clock);
    reset = r; stall = s; jump_taken = j; jump_target = t;
    #1;
    if (!r) check32("imem_en", {31'b0, imem_en}, {31'b0, j | (!s && !m_halted)});
    @(posedge clock);
    model_edge(r, s, j, t);
  endtask

  task automatic settle();
    #2;
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check32("instr", instr, e.instr);
      check32("pc_id", pc_id, e.pc_id);
      check32("imem_addr", imem_addr, e.addr);
      check32("halted", {31'b0, halted}, {31'b0, e.halted});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] frozen;
    logic [31:0] t;
    reset = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_target = 32'h0;

    step(1, 0, 0, 0); step(1, 0, 0, 0); settle();
    check32("reset_instr", instr, 32'h0);
    check32("reset_addr", imem_addr, 32'h0);

    step(0, 0, 0, 0); settle();
    check32("edge1_instr", instr, 32'h0);
    step(0, 0, 0, 0); settle();
    check32("edge2_instr", instr, 32'h1000_0000);
    check32("edge2_pc_id", pc_id, 32'h4);
    step(0, 0, 0, 0); settle();
    check32("edge3_instr", instr, 32'h1000_0004);
    check32("edge3_pc_id", pc_id, 32'h8);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    settle();
    check32("stall_instr", instr, 32'h1000_0004);
    step(0, 0, 0, 0); settle();
    check32("unstall_instr", instr, 32'h1000_0008);

    step(0, 0, 1, 32'h40); settle();
    check32("jump_instr", instr, 32'h0);
    check32("jump_addr", imem_addr, 32'h40);
    step(0, 0, 0, 0); step(0, 0, 0, 0); settle();
    check32("jump_target_instr", instr, 32'h1000_0040);
    check32("jump_target_pc_id", pc_id, 32'h44);

    step(0, 1, 1, 32'h83); step(0, 0, 0, 0); step(0, 0, 0, 0); settle();
    check32("jump_stall_instr", instr, 32'h1000_0080);

    halt_mode = 1'b1;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    settle();
    check32("halt_word", instr, 32'hFC00_0000);
    step(0, 0, 0, 0); settle();
    check32("halted_flag", {31'b0, halted}, 32'h1);
    check32("halted_instr", instr, 32'h0);
    frozen = imem_addr;
    for (int i = 0; i < 10; i++) step(0, (i % 3) == 0, 0, 0);
    settle();
    check32("halted_addr_frozen", imem_addr, frozen);
    step(0, 0, 1, 32'h0); settle();
    check32("unhalt", {31'b0, halted}, 32'h0);
    step(0, 0, 0, 0); step(0, 0, 0, 0); settle();
    check32("refetch0", instr, 32'h1000_0000);

    halt_mode = 1'b0;
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h20); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    step(1, 1, 0, 0); settle();
    check32("rst_stall_instr", instr, 32'h0);
    check32("rst_stall_addr", imem_addr, 32'h0);

    for (int i = 0; i < 2000; i++) begin
      t = $urandom();
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | ($urandom() & 32'h1F);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, t);
    end

    @(posedge clock); #3;
    check32("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
